// File: rtl/ofdm_symbol_framer_if.sv
// Avalon-ST sink/source bundle for the OFDM symbol framer.
// The slave modport is the framer's view; the master modport is the upstream/downstream side.
interface ofdm_symbol_framer_if;
  logic [31:0] asi_in0_data;
  logic        asi_in0_valid;
  logic        asi_in0_ready;
  logic        asi_in0_startofpacket;
  logic        asi_in0_endofpacket;
  logic [31:0] aso_out0_data;
  logic        aso_out0_valid;
  logic        aso_out0_startofpacket;
  logic        aso_out0_endofpacket;

  modport slave (
    input  asi_in0_data,
    input  asi_in0_valid,
    output asi_in0_ready,
    input  asi_in0_startofpacket,
    input  asi_in0_endofpacket,
    output aso_out0_data,
    output aso_out0_valid,
    output aso_out0_startofpacket,
    output aso_out0_endofpacket
  );

  modport master (
    output asi_in0_data,
    output asi_in0_valid,
    input  asi_in0_ready,
    output asi_in0_startofpacket,
    output asi_in0_endofpacket,
    input  aso_out0_data,
    input  aso_out0_valid,
    input  aso_out0_startofpacket,
    input  aso_out0_endofpacket
  );
endinterface

// File: rtl/ofdm_symbol_framer.sv
// OFDM transmit framer: buffers one symbol, then emits preamble, cyclic prefix,
// body and a zero guard gap at the sample_tick rate, with zeros between frames.
module ofdm_symbol_framer #(
  parameter int          SYMBOL_LEN     = 64,
  parameter int          CP_LEN         = 16,
  parameter int          PREAMBLE_LEN   = 32,
  parameter logic [15:0] PREAMBLE_LEVEL = 16'd1024,
  parameter int          GAP_LEN        = 64,
  parameter bit          NEGATE         = 1'b1
) (
  input  logic                      clock_clk,
  input  logic                      reset_reset,
  input  logic                      sample_tick,
  ofdm_symbol_framer_if.slave       st,
  output logic                      tx_busy,
  output logic                      frame_error
);

  localparam int PTR_W   = $clog2(SYMBOL_LEN);
  localparam int MAX_PG  = (PREAMBLE_LEN > GAP_LEN) ? PREAMBLE_LEN : GAP_LEN;
  localparam int MAX_LEN = (MAX_PG > SYMBOL_LEN) ? MAX_PG : SYMBOL_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(SYMBOL_LEN - 1);
  localparam logic [PTR_W-1:0] CP_BASE  = PTR_W'(SYMBOL_LEN - CP_LEN);

  typedef enum logic [2:0] {
    S_FILL,
    S_PREAMBLE,
    S_CP,
    S_BODY,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic              frame_error_q, frame_error_d;

  logic [31:0]       sym_mem_q [SYMBOL_LEN];
  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  logic [PTR_W-1:0]  rd_addr;
  logic [31:0]       rd_data;
  logic              accept;

  // Two's-complement negate per field; 0x8000 wraps back onto itself.
  function automatic logic [31:0] shape(input logic [31:0] x);
    if (NEGATE)
      return {16'h0000 - x[31:16], 16'h0000 - x[15:0]};
    else
      return x;
  endfunction

  assign accept  = st.asi_in0_valid && (state_q == S_FILL);
  assign rd_addr = (state_q == S_CP) ? (CP_BASE + cnt_q[PTR_W-1:0]) : cnt_q[PTR_W-1:0];
  assign rd_data = sym_mem_q[rd_addr];

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    drop_d        = drop_q;
    cnt_d         = cnt_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    out_sop_d     = 1'b0;
    out_eop_d     = 1'b0;
    frame_error_d = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = wptr_q;

    // Packet capture; drop mode swallows the tail of an overlong packet.
    if (accept) begin
      if (drop_q) begin
        if (st.asi_in0_endofpacket)
          drop_d = 1'b0;
      end else if (st.asi_in0_startofpacket) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        if (st.asi_in0_endofpacket) begin
          frame_error_d = 1'b1;
          wptr_d        = '0;
        end else begin
          wptr_d = PTR_W'(1);
        end
      end else if (wptr_q != '0) begin
        wr_en = 1'b1;
        if (wptr_q == LAST_IDX) begin
          wptr_d = '0;
          if (st.asi_in0_endofpacket) begin
            state_d = S_PREAMBLE;
            cnt_d   = '0;
          end else begin
            frame_error_d = 1'b1;
            drop_d        = 1'b1;
          end
        end else if (st.asi_in0_endofpacket) begin
          frame_error_d = 1'b1;
          wptr_d        = '0;
        end else begin
          wptr_d = wptr_q + PTR_W'(1);
        end
      end
    end

    if (sample_tick) begin
      out_valid_d = 1'b1;
      out_data_d  = 32'h0;
      case (state_q)
        S_PREAMBLE: begin
          out_data_d = {16'h0000, PREAMBLE_LEVEL};
          out_sop_d  = (cnt_q == '0);
          if (cnt_q == CNT_W'(PREAMBLE_LEN - 1)) begin
            state_d = S_CP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_CP: begin
          out_data_d = shape(rd_data);
          if (cnt_q == CNT_W'(CP_LEN - 1)) begin
            state_d = S_BODY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BODY: begin
          out_data_d = shape(rd_data);
          if (cnt_q == CNT_W'(SYMBOL_LEN - 1)) begin
            out_eop_d = 1'b1;
            state_d   = S_GAP;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == CNT_W'(GAP_LEN - 1)) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          out_data_d = 32'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q       <= S_FILL;
      wptr_q        <= '0;
      drop_q        <= 1'b0;
      cnt_q         <= '0;
      out_data_q    <= 32'h0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      drop_q        <= drop_d;
      cnt_q         <= cnt_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Symbol store has no reset; its contents only matter after a full packet.
  always_ff @(posedge clock_clk) begin
    if (wr_en)
      sym_mem_q[wr_addr] <= st.asi_in0_data;
  end

  assign st.asi_in0_ready          = (state_q == S_FILL);
  assign st.aso_out0_data          = out_data_q;
  assign st.aso_out0_valid         = out_valid_q;
  assign st.aso_out0_startofpacket = out_sop_q;
  assign st.aso_out0_endofpacket   = out_eop_q;
  assign tx_busy                   = (state_q != S_FILL);
  assign frame_error               = frame_error_q;

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Scoreboard bench for ofdm_symbol_framer: one NEGATE=1 and one NEGATE=0 instance
// share the same input stream; expected frames are queued per instance.
module tb_ofdm_symbol_framer;

   localparam int SYMBOL_LEN   = 64;
   localparam int CP_LEN       = 16;
   localparam int PREAMBLE_LEN = 32;
   localparam int GAP_LEN      = 64;
   localparam int FRAME_LEN    = PREAMBLE_LEN + CP_LEN + SYMBOL_LEN + GAP_LEN;

   logic        clock_clk   = 1'b0;
   logic        reset_reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic [31:0] inData      = 32'h0;
   logic        inValid     = 1'b0;
   logic        inSop       = 1'b0;
   logic        inEop       = 1'b0;

   logic        txBusy   [2];
   logic        frameErr [2];
   logic [31:0] outData  [2];
   logic        outValid [2];
   logic        outSop   [2];
   logic        outEop   [2];
   logic        inReady  [2];

   int          checks    = 0;
   int          failures  = 0;
   int          tickMode  = 0;
   int          tickDiv   = 0;
   int          errCnt    [2];
   int          frameLeft [2];
   logic [33:0] expQ      [2][$];

   ofdm_symbol_framer_if bus0 ();
   ofdm_symbol_framer_if bus1 ();

   assign bus0.asi_in0_data         = inData;
   assign bus0.asi_in0_valid        = inValid;
   assign bus0.asi_in0_startofpacket = inSop;
   assign bus0.asi_in0_endofpacket  = inEop;
   assign bus1.asi_in0_data         = inData;
   assign bus1.asi_in0_valid        = inValid;
   assign bus1.asi_in0_startofpacket = inSop;
   assign bus1.asi_in0_endofpacket  = inEop;

   assign outData[0]  = bus0.aso_out0_data;
   assign outValid[0] = bus0.aso_out0_valid;
   assign outSop[0]   = bus0.aso_out0_startofpacket;
   assign outEop[0]   = bus0.aso_out0_endofpacket;
   assign inReady[0]  = bus0.asi_in0_ready;
   assign outData[1]  = bus1.aso_out0_data;
   assign outValid[1] = bus1.aso_out0_valid;
   assign outSop[1]   = bus1.aso_out0_startofpacket;
   assign outEop[1]   = bus1.aso_out0_endofpacket;
   assign inReady[1]  = bus1.asi_in0_ready;

   ofdm_symbol_framer #(
      .SYMBOL_LEN(SYMBOL_LEN), .CP_LEN(CP_LEN), .PREAMBLE_LEN(PREAMBLE_LEN),
      .PREAMBLE_LEVEL(16'd1024), .GAP_LEN(GAP_LEN), .NEGATE(1'b1)
   ) u_dut_neg (
      .clock_clk(clock_clk), .reset_reset(reset_reset), .sample_tick(sample_tick),
      .st(bus0), .tx_busy(txBusy[0]), .frame_error(frameErr[0])
   );

   ofdm_symbol_framer #(
      .SYMBOL_LEN(SYMBOL_LEN), .CP_LEN(CP_LEN), .PREAMBLE_LEN(PREAMBLE_LEN),
      .PREAMBLE_LEVEL(16'd1024), .GAP_LEN(GAP_LEN), .NEGATE(1'b0)
   ) u_dut_pos (
      .clock_clk(clock_clk), .reset_reset(reset_reset), .sample_tick(sample_tick),
      .st(bus1), .tx_busy(txBusy[1]), .frame_error(frameErr[1])
   );

   always #5 clock_clk = ~clock_clk;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [33:0] got, input logic [33:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference sample shaping: field-wise 16-bit negation when enabled.
   function automatic logic [31:0] refShape(input logic [31:0] x, input bit neg);
      logic [15:0] re;
      logic [15:0] im;
      re = x[31:16];
      im = x[15:0];
      if (neg) begin
         re = 16'h0000 - re;
         im = 16'h0000 - im;
      end
      return {re, im};
   endfunction

   // Drives one input packet (one beat per cycle) and queues the expected frame if it should air.
   task automatic applyStimulus(input int numBeats, input int eopBeat, input int specialIdx, input bit expectTx);
      logic [31:0] beats [SYMBOL_LEN];
      logic [31:0] val;
      for (int i = 0; i < numBeats; i++) begin
         @(posedge clock_clk);
         #1;
         val = (i == specialIdx) ? 32'h8000_7FFF : {16'(i), 16'(i)};
         inValid = 1'b1;
         inSop   = (i == 0);
         inEop   = (i == eopBeat);
         inData  = val;
         if (i < SYMBOL_LEN) beats[i] = val;
      end
      @(posedge clock_clk);
      #1;
      inValid = 1'b0;
      inSop   = 1'b0;
      inEop   = 1'b0;
      inData  = 32'h0;
      if (expectTx) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < PREAMBLE_LEN; p++)
               expQ[d].push_back({(p == 0), 1'b0, 32'h0000_0400});
            for (int k = 0; k < CP_LEN; k++)
               expQ[d].push_back({2'b00, refShape(beats[SYMBOL_LEN - CP_LEN + k], (d == 0))});
            for (int k = 0; k < SYMBOL_LEN; k++)
               expQ[d].push_back({1'b0, (k == SYMBOL_LEN - 1), refShape(beats[k], (d == 0))});
            for (int g = 0; g < GAP_LEN; g++)
               expQ[d].push_back(34'h0);
         end
      end
   endtask

   // Waits (bounded) for the current frame to finish, counting the ticks it consumed.
   task automatic waitFrameDone(input string tag, input bit checkTicks);
      int  ticks = 0;
      int  cyc   = 0;
      bit  seen  = 1'b0;
      while (cyc < 4000 && !(seen && !txBusy[0])) begin
         @(negedge clock_clk);
         cyc++;
         if (txBusy[0]) begin
            seen = 1'b1;
            if (sample_tick) ticks++;
         end
      end
      checkOutput({tag, "_done"}, 34'(txBusy[0]), 34'd0);
      if (checkTicks) checkOutput({tag, "_ticks"}, 34'(ticks), 34'(FRAME_LEN));
      checkOutput({tag, "_ready0"}, 34'(inReady[0]), 34'd1);
      checkOutput({tag, "_ready1"}, 34'(inReady[1]), 34'd1);
   endtask

   task automatic checkQuiet(input string tag);
      for (int d = 0; d < 2; d++) begin
         checkOutput($sformatf("%s_valid%0d", tag, d), 34'(outValid[d]), 34'd0);
         checkOutput($sformatf("%s_data%0d", tag, d), 34'(outData[d]), 34'd0);
         checkOutput($sformatf("%s_flags%0d", tag, d), 34'({outSop[d], outEop[d], txBusy[d], frameErr[d]}), 34'd0);
      end
   endtask

   // Tick generator: 0 = none, 1 = every 4th cycle, 2 = every cycle.
   initial begin
      forever begin
         @(posedge clock_clk);
         #1;
         tickDiv++;
         sample_tick = (tickMode == 2) || (tickMode == 1 && (tickDiv % 4) == 0);
      end
   end

   // Output monitor: idle samples must be zero, framed samples come from the scoreboard.
   initial begin
      errCnt[0] = 0;
      errCnt[1] = 0;
      frameLeft[0] = 0;
      frameLeft[1] = 0;
      forever begin
         @(negedge clock_clk);
         for (int d = 0; d < 2; d++) begin
            if (reset_reset) begin
               frameLeft[d] = 0;
            end else begin
               if (frameErr[d]) errCnt[d]++;
               if (outValid[d]) begin
                  if (frameLeft[d] == 0 && !outSop[d]) begin
                     checkOutput($sformatf("dut%0d_idle", d), {outSop[d], outEop[d], outData[d]}, 34'h0);
                  end else begin
                     if (frameLeft[d] == 0) frameLeft[d] = FRAME_LEN;
                     if (expQ[d].size() == 0)
                        checkOutput($sformatf("dut%0d_sb_underflow", d), 34'(expQ[d].size()), 34'd1);
                     else
                        checkOutput($sformatf("dut%0d_sample", d), {outSop[d], outEop[d], outData[d]}, expQ[d].pop_front());
                     frameLeft[d]--;
                  end
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int e0;
      int e1;
      int vcnt;

      // Reset state
      repeat (3) @(posedge clock_clk);
      #1;
      checkQuiet("reset");
      checkOutput("reset_ready", 34'({inReady[0], inReady[1]}), 34'b11);
      @(posedge clock_clk);
      #1;
      reset_reset = 1'b0;
      tickMode    = 1;
      repeat (10) @(posedge clock_clk);

      $display("[TB] nominal packet");
      applyStimulus(64, 63, -1, 1'b1);
      waitFrameDone("nominal", 1'b1);

      $display("[TB] short packet");
      e0 = errCnt[0];
      e1 = errCnt[1];
      applyStimulus(11, 10, -1, 1'b0);
      repeat (20) @(negedge clock_clk);
      checkOutput("short_err0", 34'(errCnt[0] - e0), 34'd1);
      checkOutput("short_err1", 34'(errCnt[1] - e1), 34'd1);
      checkOutput("short_busy", 34'(txBusy[0]), 34'd0);
      checkOutput("short_ready", 34'(inReady[0]), 34'd1);

      $display("[TB] good packet with 0x8000_7FFF at index 60");
      applyStimulus(64, 63, 60, 1'b1);
      waitFrameDone("boundary", 1'b1);

      $display("[TB] long packet");
      e0 = errCnt[0];
      applyStimulus(70, 69, -1, 1'b0);
      repeat (20) @(negedge clock_clk);
      checkOutput("long_err", 34'(errCnt[0] - e0), 34'd1);
      checkOutput("long_busy", 34'(txBusy[0]), 34'd0);

      $display("[TB] backpressure during body");
      applyStimulus(64, 63, -1, 1'b1);
      repeat (250) @(posedge clock_clk);
      #1;
      inValid = 1'b1;
      inSop   = 1'b1;
      inData  = 32'hDEAD_BEEF;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock_clk);
         checkOutput("bp_ready", 34'(inReady[0]), 34'd0);
      end
      @(posedge clock_clk);
      #1;
      inValid = 1'b0;
      inSop   = 1'b0;
      inData  = 32'h0;
      waitFrameDone("backpressure", 1'b0);

      $display("[TB] continuous ticks");
      tickMode = 2;
      applyStimulus(64, 63, -1, 1'b1);
      waitFrameDone("continuous", 1'b1);

      $display("[TB] no ticks");
      tickMode = 0;
      repeat (3) @(posedge clock_clk);
      vcnt = 0;
      repeat (20) begin
         @(negedge clock_clk);
         if (outValid[0] || outValid[1]) vcnt++;
      end
      checkOutput("noticks_valid", 34'(vcnt), 34'd0);

      $display("[TB] reset during cyclic prefix");
      tickMode = 1;
      applyStimulus(64, 63, -1, 1'b1);
      repeat (140) @(posedge clock_clk);
      #1;
      checkOutput("midreset_busy", 34'(txBusy[0]), 34'd1);
      #1;
      reset_reset = 1'b1;
      expQ[0].delete();
      expQ[1].delete();
      #1;
      checkQuiet("midreset");
      repeat (3) @(posedge clock_clk);
      #1;
      reset_reset = 1'b0;
      @(negedge clock_clk);
      checkOutput("postreset_ready", 34'({inReady[0], inReady[1]}), 34'b11);
      checkOutput("postreset_busy", 34'(txBusy[0]), 34'd0);
      applyStimulus(64, 63, -1, 1'b1);
      waitFrameDone("after_reset", 1'b1);

      repeat (10) @(negedge clock_clk);
      checkOutput("sb_drained0", 34'(expQ[0].size()), 34'd0);
      checkOutput("sb_drained1", 34'(expQ[1].size()), 34'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
